// File: rtl/dvi_timing_ctrl.sv
// DVI video timing controller: frame-aligned IDLE/RUN sequencing of hsync, vsync, de,
// pixel coordinates and a look-ahead pixel request, all registered in the pixelclk domain.
module dvi_timing_ctrl #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   REQ_LEAD = 2
) (
  input  logic        pixelclk,
  input  logic        rst,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pixel_req,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] HA0_12 = 12'(HA0);
  localparam logic [11:0] VA0_12 = 12'(VA0);

  // 13-bit bounds: the active end can equal 4096 when a total is exactly 4096.
  localparam logic [12:0] HS_END = 13'(H_SYNC);
  localparam logic [12:0] VS_END = 13'(V_SYNC);
  localparam logic [12:0] HA_BEG = 13'(HA0);
  localparam logic [12:0] HA_END = 13'(HA0 + H_ACTIVE);
  localparam logic [12:0] VA_BEG = 13'(VA0);
  localparam logic [12:0] VA_END = 13'(VA0 + V_ACTIVE);
  localparam logic [12:0] LEAD   = 13'(REQ_LEAD);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        pixel_req_q, pixel_req_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;

  logic        run_d;
  logic [12:0] h_ext, v_ext, h_lead;
  logic        h_act, v_act, h_req;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          h_d     = '0;
          v_d     = '0;
        end
      end
      RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            // enable only matters here, on the last cycle of a frame
            if (!enable) state_d = IDLE;
          end else begin
            v_d = v_q + 12'd1;
          end
        end else begin
          h_d = h_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next counter value so they line up with the counters.
  always_comb begin
    run_d  = (state_d == RUN);
    h_ext  = {1'b0, h_d};
    v_ext  = {1'b0, v_d};
    h_lead = h_ext + LEAD;
    h_act  = (h_ext >= HA_BEG) && (h_ext < HA_END);
    v_act  = (v_ext >= VA_BEG) && (v_ext < VA_END);
    h_req  = (h_lead >= HA_BEG) && (h_lead < HA_END);

    hsync_d       = (run_d && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = (run_d && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
    de_d          = run_d && h_act && v_act;
    pixel_req_d   = run_d && h_req && v_act;
    x_d           = de_d ? (h_d - HA0_12) : 12'd0;
    y_d           = de_d ? (v_d - VA0_12) : 12'd0;
    line_start_d  = run_d && (h_d == 12'd0);
    frame_start_d = line_start_d && (v_d == 12'd0);
    busy_d        = run_d;
  end

  always_ff @(posedge pixelclk) begin
    if (rst) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      pixel_req_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pixel_req_q   <= pixel_req_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel_req   = pixel_req_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Scoreboard bench for dvi_timing_ctrl: a frame-position model predicts each cycle's
// outputs for a positive- and a negative-polarity instance driven by the same stimulus.
module tb_dvi_timing_ctrl;

  localparam int HAC = 8, HFP = 2, HSY = 3, HBP = 3;
  localparam int VAC = 4, VFP = 1, VSY = 2, VBP = 1;
  localparam int LEAD = 2;
  localparam int HT = HSY + HBP + HAC + HFP;
  localparam int VT = VSY + VBP + VAC + VFP;
  localparam int FT = HT * VT;
  localparam int HA0 = HSY + HBP;
  localparam int VA0 = VSY + VBP;

  logic clk;
  logic rst;
  logic enable;

  logic        hs_p, vs_p, de_p, req_p, ls_p, fs_p, busy_p;
  logic [11:0] x_p, y_p;
  logic        hs_n, vs_n, de_n, req_n, ls_n, fs_n, busy_n;
  logic [11:0] x_n, y_n;

  dvi_timing_ctrl #(
    .H_ACTIVE(HAC), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VAC), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(LEAD)
  ) dut (
    .pixelclk(clk), .rst(rst), .enable(enable),
    .hsync(hs_p), .vsync(vs_p), .de(de_p), .pixel_req(req_p),
    .x(x_p), .y(y_p), .line_start(ls_p), .frame_start(fs_p), .busy(busy_p)
  );

  dvi_timing_ctrl #(
    .H_ACTIVE(HAC), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VAC), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(LEAD)
  ) dut_n (
    .pixelclk(clk), .rst(rst), .enable(enable),
    .hsync(hs_n), .vsync(vs_n), .de(de_n), .pixel_req(req_n),
    .x(x_n), .y(y_n), .line_start(ls_n), .frame_start(fs_n), .busy(busy_n)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs, vs, de, req;
    logic [11:0] x, y;
    logic        ls, fs, busy, rst;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;

  // Reference model: running flag plus linear position within the frame.
  bit m_run = 0;
  int m_pos = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic exp_t predict(input bit run, input int pos, input bit r);
    exp_t e;
    int h, v;
    bit row, col;
    h = pos % HT;
    v = pos / HT;
    row = (v >= VA0) && (v < VA0 + VAC);
    col = (h >= HA0) && (h < HA0 + HAC);
    e.hs   = run && (h < HSY);
    e.vs   = run && (v < VSY);
    e.de   = run && row && col;
    e.req  = run && row && (h + LEAD >= HA0) && (h + LEAD < HA0 + HAC);
    e.x    = e.de ? 12'(h - HA0) : 12'd0;
    e.y    = e.de ? 12'(v - VA0) : 12'd0;
    e.ls   = run && (h == 0);
    e.fs   = run && (pos == 0);
    e.busy = run;
    e.rst  = r;
    return e;
  endfunction

  task automatic step(input bit r, input bit e);
    @(negedge clk);
    rst    = r;
    enable = e;
    if (r) begin
      m_run = 0;
      m_pos = 0;
    end else if (!m_run) begin
      if (e) begin
        m_run = 1;
        m_pos = 0;
      end
    end else if (m_pos == FT - 1) begin
      m_pos = 0;
      if (!e) m_run = 0;
    end else begin
      m_pos++;
    end
    q.push_back(predict(m_run, m_pos, r));
  endtask

  // Monitor: pops one expectation per clock and compares both instances.
  int  de_cnt = 0, req_cnt = 0;
  bit  dirty  = 1;
  bit  busy_h1 = 0, busy_h2 = 0;
  bit  req_h1 = 0, req_h2 = 0;
  exp_t ex;

  always @(posedge clk) begin
    #1;
    if (q.size() == 0) begin
      if (!done) chk("queue_underflow", 0, 1);
    end else begin
      ex = q.pop_front();
      chk("hsync",       hs_p,   ex.hs);
      chk("vsync",       vs_p,   ex.vs);
      chk("de",          de_p,   ex.de);
      chk("pixel_req",   req_p,  ex.req);
      chk("x",           x_p,    ex.x);
      chk("y",           y_p,    ex.y);
      chk("line_start",  ls_p,   ex.ls);
      chk("frame_start", fs_p,   ex.fs);
      chk("busy",        busy_p, ex.busy);
      chk("hsync_neg",   hs_n,   !ex.hs);
      chk("vsync_neg",   vs_n,   !ex.vs);
      chk("de_neg",      de_n,   ex.de);
      chk("req_neg",     req_n,  ex.req);
      chk("x_neg",       x_n,    ex.x);
      chk("y_neg",       y_n,    ex.y);
      chk("fs_neg",      fs_n,   ex.fs);
      chk("busy_neg",    busy_n, ex.busy);
      if (ls_n != ex.ls) chk("ls_neg", ls_n, ex.ls);

      // Each de must be preceded by pixel_req exactly LEAD cycles earlier.
      if (ex.busy && busy_h1 && busy_h2) chk("req_lead", req_h2, de_p);

      if (ex.rst) dirty = 1;
      if (fs_p) begin
        if (!dirty) begin
          chk("de_per_frame",  de_cnt,  HAC * VAC);
          chk("req_per_frame", req_cnt, HAC * VAC);
        end
        de_cnt  = 0;
        req_cnt = 0;
        dirty   = 0;
      end
      de_cnt  += int'(de_p);
      req_cnt += int'(req_p);
      busy_h2 = busy_h1;
      busy_h1 = ex.busy;
      req_h2  = req_h1;
      req_h1  = req_p;
    end
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b1;

    // Reset with enable held high, then release: first edge starts a frame.
    repeat (3) step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Two frames with random single-cycle enable drops away from the frame boundary.
    for (int i = 0; i < 2 * FT - 1; i++)
      step(1'b0, (m_pos == FT - 1) ? 1'b1 : ($urandom_range(0, 7) != 0));

    // Drop enable at line 4: frame completes, then IDLE with no new frame.
    for (int i = 0; i < 2 * FT && !(m_run && m_pos == 4 * HT); i++) step(1'b0, 1'b1);
    repeat (FT + 80) step(1'b0, 1'b0);

    // Restart, then reset in the middle of an active line (line 4, h=9).
    step(1'b0, 1'b1);
    for (int i = 0; i < 2 * FT && !(m_run && m_pos == 4 * HT + 9); i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    repeat (FT + 20) step(1'b0, 1'b1);

    // Randomized enable with occasional resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);

    @(posedge clk);
    #2;
    done = 1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
